req_serial_encoder: RTL and testbench
=====================================

Name: req_serial_encoder

Overview:
- Inverse of the team's 3-to-8 one-hot decoder: accepts a multi-hot N-bit request vector and emits the binary index of every set bit, one per handshake.
- Emission order is lowest index first.
- Used wherever the decoder's one-hot outputs must be turned back into indices, e.g. request collection and cross-check loops around the decoder.
- Buffers one vector, uses a valid/ready handshake on both sides, and supports a synchronous flush.

Parameters:
- N, 8, request vector width; power of two, N >= 2.
- W, 3, index width; must equal clog2(N).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; drops any pending vector.
- req  in  N  multi-hot request vector.
- req_valid  in  1  req is valid this cycle.
- req_ready  out  1  block can accept a vector.
- out_idx  out  W  binary index of the current lowest pending bit.
- out_onehot  out  N  one-hot decode of out_idx (1 << out_idx).
- out_valid  out  1  out_idx/out_onehot are valid.
- out_ready  in  1  consumer accepts the current index.
- out_last  out  1  current index is the final pending bit of the vector.
- zero_seen  out  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, mask=0, out_valid=0, out_idx=0, out_onehot=0, out_last=0, zero_seen=0, req_ready=1 once rst_n is released.
- States: IDLE and BUSY.
- IDLE:
  - req_ready=1, out_valid=0.
  - Acceptance is req_valid && req_ready on a rising edge.
  - If req != 0 at acceptance: mask <= req, go to BUSY.
  - If req == 0 at acceptance: stay in IDLE, zero_seen=1 in the following cycle only.
- BUSY:
  - req_ready=0, out_valid=1.
  - out_idx = index of the lowest set bit of mask.
  - out_onehot = mask & -mask (lowest set bit isolated).
  - out_last = 1 iff mask has exactly one bit set.
- Output handshake: an index transfers when out_valid && out_ready. On transfer, mask <= mask with the emitted bit cleared; if out_last was 1, go to IDLE.
- Latency:
  - First index is valid the cycle after acceptance.
  - With out_ready held high, one index transfers per cycle.
  - A K-bit vector occupies BUSY for exactly K cycles.
- Back-pressure: while out_ready=0, out_idx, out_onehot and out_last hold stable and out_valid stays 1.
- Overlap: no new vector is accepted in BUSY. req_ready rises the cycle after the last transfer, giving a 1-cycle IDLE bubble between vectors.
- clr:
  - Takes priority over all handshakes in the same cycle.
  - Next state is mask=0, IDLE, zero_seen=0.
  - Any pending indices are discarded, and a vector offered in the clr cycle is not accepted.
- Outputs are driven from registered mask/state through combinational encode; there is no input-to-output combinational path.
- N=8 ordering: req=8'b1000_0001 emits 0 then 7; all-ones emits 0..7 with out_last only on 7.
- Input req is sampled only at acceptance; changes afterwards are ignored.

Decomposition:
- Shared package: N, W, state enum {IDLE, BUSY}, and the function popcount_is_one.
- One sub-module, prio_enc_lsb.
  - Combinational: input N-bit vector; outputs W-bit index of the lowest set bit plus an any-bit-set flag.
  - Reusable elsewhere for arbitration.
- out_onehot is regenerated inside the top level rather than by instantiating the decoder, so the top stays self-contained.

Test Plan:
- Reset mid-BUSY: load 8'hFF, transfer 3 indices, pulse rst_n low -> all outputs 0 immediately, then req_ready=1, out_valid=0.
- Single bit: req=8'b0010_0000 with out_ready=1 -> next cycle out_idx=5, out_onehot=8'h20, out_last=1; IDLE one cycle later.
- Multi-hot with back-pressure: req=8'b1001_0110, out_ready toggled 1/0 -> indices 1,2,4,7 in order, each stable while stalled, out_last only with 7.
- Zero vector: req=0, req_valid=1 -> zero_seen pulses exactly one cycle, out_valid never asserts, req_ready stays 1.
- Flush: load 8'hF0, transfer 4, assert clr together with req_valid and req=8'h01 -> IDLE, no index 5-7 emitted, 8'h01 not accepted.
- Back-to-back vectors 8'h81 then 8'h42 with req_valid held -> emitted indices 0,7,1,6 with exactly one bubble cycle between vectors.

Source files
------------

// File: rtl/req_serial_encoder_pkg.sv
// Shared constants, FSM state type and helpers for the request serial encoder.
// Imported by the interface, the priority encoder user and the top level.
package req_serial_encoder_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = $clog2(N);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  // True when exactly one bit of v is set (v is a nonzero power of two).
  function automatic logic popcount_is_one(logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

endpackage

// File: rtl/req_serial_encoder_if.sv
// Request and index handshake bundle for req_serial_encoder.
// The slave modport is the encoder; the master modport is its producer/consumer.
interface req_serial_encoder_if;
  import req_serial_encoder_pkg::*;

  logic [N-1:0] req;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         zero_seen;

  modport slave (
    input  req,
    input  req_valid,
    output req_ready,
    output out_idx,
    output out_onehot,
    output out_valid,
    input  out_ready,
    output out_last,
    output zero_seen
  );

  modport master (
    output req,
    output req_valid,
    input  req_ready,
    input  out_idx,
    input  out_onehot,
    input  out_valid,
    output out_ready,
    input  out_last,
    input  zero_seen
  );

endinterface

// File: rtl/req_serial_encoder_prio_enc_lsb.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
// Parameterised so it can be reused for arbitration.
module prio_enc_lsb #(
  parameter int unsigned Width = 8,
  parameter int unsigned IdxW  = $clog2(Width)
) (
  input  logic [Width-1:0] vec_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/req_serial_encoder.sv
// Serialises a multi-hot request vector into binary indices, lowest first,
// one per output handshake; buffers one vector and supports a synchronous flush.
module req_serial_encoder
  import req_serial_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  req_serial_encoder_if.slave  bus
);

  state_e       state_q;
  logic [N-1:0] mask_q;
  logic         zero_seen_q;

  logic [W-1:0] low_idx;
  logic         mask_any;
  logic [N-1:0] low_onehot;
  logic         busy;
  logic         last;

  prio_enc_lsb #(
    .Width (N),
    .IdxW  (W)
  ) u_prio_enc (
    .vec_i (mask_q),
    .idx_o (low_idx),
    .any_o (mask_any)
  );

  // Two's-complement isolation of the lowest set bit; zero when mask is empty.
  assign low_onehot = mask_q & (~mask_q + N'(1));
  assign busy       = (state_q == StBusy);
  assign last       = busy && popcount_is_one(mask_q);

  // Ready is held low while reset is asserted so every output reads zero.
  assign bus.req_ready  = (state_q == StIdle) && rst_n;
  assign bus.out_valid  = busy && mask_any;
  assign bus.out_idx    = low_idx;
  assign bus.out_onehot = low_onehot;
  assign bus.out_last   = last;
  assign bus.zero_seen  = zero_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      zero_seen_q <= 1'b0;
    end else begin
      zero_seen_q <= 1'b0;
      if (clr) begin
        state_q <= StIdle;
        mask_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.req_valid) begin
              if (bus.req != '0) begin
                mask_q  <= bus.req;
                state_q <= StBusy;
              end else begin
                zero_seen_q <= 1'b1;
              end
            end
          end
          StBusy: begin
            if (bus.out_ready) begin
              mask_q <= mask_q & ~low_onehot;
              if (last) begin
                state_q <= StIdle;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            mask_q  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_req_serial_encoder.sv
// Directed self-checking bench for req_serial_encoder with hand-computed expectations.
module tb_req_serial_encoder;
  import req_serial_encoder_pkg::*;

  logic clk;
  logic rst_n;
  logic clr;

  int n_cmp;
  int n_bad;

  req_serial_encoder_if bus ();

  req_serial_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int idx, input logic lst);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_idx"}, 32'(bus.out_idx), 32'(idx));
    check_eq({tag, "_onehot"}, 32'(bus.out_onehot), 32'(oh));
    check_eq({tag, "_last"}, 32'(bus.out_last), 32'(lst));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_idx [4];
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.req = '0;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_idx", 32'(bus.out_idx), 32'd0);
    check_eq("rst_onehot", 32'(bus.out_onehot), 32'd0);
    check_eq("rst_last", 32'(bus.out_last), 32'd0);
    check_eq("rst_zero", 32'(bus.zero_seen), 32'd0);
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    // Single bit 5
    bus.req = 8'b0010_0000;
    bus.req_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check_out("single", 5, 1'b1);
    check_eq("single_rdy", 32'(bus.req_ready), 32'd0);
    tick();
    check_idle("single_done");

    // Multi-hot with back-pressure; req changes after acceptance are ignored
    exp_idx = '{1, 2, 4, 7};
    bus.req = 8'b1001_0110;
    bus.req_valid = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    bus.req = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      bus.out_ready = 1'b0;
      check_out($sformatf("bp%0d", k), exp_idx[k], k == 3);
      tick();
      check_out($sformatf("bp%0d_stall", k), exp_idx[k], k == 3);
      bus.out_ready = 1'b1;
      tick();
    end
    check_idle("bp_done");

    // Zero vector
    bus.req = '0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check_eq("zero_pulse", 32'(bus.zero_seen), 32'd1);
    check_idle("zero_a");
    tick();
    check_eq("zero_end", 32'(bus.zero_seen), 32'd0);
    check_idle("zero_b");

    // Flush after one transfer, with a competing request in the clr cycle
    bus.req = 8'hF0;
    bus.req_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check_out("fl_first", 4, 1'b0);
    tick();
    check_out("fl_second", 5, 1'b0);
    clr = 1'b1;
    bus.req = 8'h01;
    bus.req_valid = 1'b1;
    tick();
    clr = 1'b0;
    bus.req_valid = 1'b0;
    check_idle("fl_a");
    check_eq("fl_onehot", 32'(bus.out_onehot), 32'd0);
    check_eq("fl_zero", 32'(bus.zero_seen), 32'd0);
    tick();
    check_idle("fl_b");

    // Back-to-back vectors with req_valid held
    bus.req = 8'h81;
    bus.req_valid = 1'b1;
    tick();
    bus.req = 8'h42;
    check_out("b2b_0", 0, 1'b0);
    tick();
    check_out("b2b_7", 7, 1'b1);
    tick();
    check_idle("b2b_bubble");
    tick();
    bus.req_valid = 1'b0;
    check_out("b2b_1", 1, 1'b0);
    tick();
    check_out("b2b_6", 6, 1'b1);
    tick();
    check_idle("b2b_done");

    // Reset mid-BUSY
    bus.req = 8'hFF;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_out($sformatf("ff%0d", k), k, 1'b0);
      tick();
    end
    check_out("ff3", 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mrst_idx", 32'(bus.out_idx), 32'd0);
    check_eq("mrst_onehot", 32'(bus.out_onehot), 32'd0);
    check_eq("mrst_last", 32'(bus.out_last), 32'd0);
    check_eq("mrst_ready", 32'(bus.req_ready), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check_idle("mrst_after");
    tick();
    check_idle("mrst_after2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
